imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the core's fetch port and a
//  program loader (debug/UART word writer). Sequences boot: holds fetch off until
//  the loader signals done, then arbitrates per cycle with loader priority and a
//  burst cap so fetch is never starved. Sits between core/loader and imem.
// PARAMETERS
//  AW         32  address width, passed to imem unmodified (imem decodes word index)
//  DW         32  data width
//  DEPTH      64  valid word entries; addr >= DEPTH is out of range
//  MAX_BURST  4   max consecutive loader grants while fetch is pending (>=1)
//  BOOT_HOLD  1   1: start in BOOT after reset; 0: start in RUN
// PORTS
//  clk        in   1   clock
//  reset      in   1   asynchronous, active-high
//  f_req      in   1   fetch read request (held until f_gnt)
//  f_addr     in   AW  fetch address
//  f_gnt      out  1   fetch accepted this cycle
//  f_rvalid   out  1   f_rdata valid (exactly 1 cycle after f_gnt)
//  f_rdata    out  DW  fetched instruction (= mem_rdata)
//  l_req      in   1   loader write request (held until l_gnt or l_err)
//  l_addr     in   AW  loader write address
//  l_wdata    in   DW  loader write data
//  l_gnt      out  1   loader write issued this cycle
//  l_err      out  1   1-cycle pulse: l_addr out of range, write dropped
//  load_done  in   1   1-cycle pulse: leave BOOT
//  booting    out  1   1 while in BOOT (core holds PC/stalls)
//  mem_addr   out  AW  to imem address
//  mem_wdata  out  DW  to imem data_in
//  mem_rw     out  1   to imem rw: 1 = read, 0 = write
//  mem_rdata  in   DW  from imem data_out (registered, 1-cycle latency)
// BEHAVIOUR
//  Reset (async): state=BOOT (RUN if BOOT_HOLD=0), burst_cnt=0, f_gnt=l_gnt=l_err=0,
//   f_rvalid=0, mem_rw=1, mem_addr=0, mem_wdata=0, booting=BOOT_HOLD.
//  Grants/mem_* are combinational from state+requests; f_rvalid, burst_cnt, state are regs.
//  mem_rw defaults to 1 every cycle nothing writes -> imem never sees a spurious write.
//  FSM: BOOT -> RUN on load_done (takes effect next cycle); RUN has no exit except reset.
//   load_done in RUN ignored.
//  BOOT: f_gnt=0 always; l_req serviced every cycle (no burst limit).
//  RUN arbitration, per cycle:
//   - only one requester -> it wins.
//   - both: loader wins unless burst_cnt==MAX_BURST, then fetch wins.
//   - burst_cnt: +1 on loader grant while f_req=1; cleared on fetch grant or
//     cycle with f_req=0; saturates at MAX_BURST.
//  Loader grant: mem_rw=0, mem_addr=l_addr, mem_wdata=l_wdata, l_gnt=1.
//  Out-of-range loader (l_addr>=DEPTH) when it would win: l_err=1, l_gnt=0,
//   mem_rw=1, no write; slot is consumed (fetch not granted that cycle), counts as a grant.
//  Fetch grant: mem_rw=1, mem_addr=f_addr, f_gnt=1; f_rvalid=1 next cycle with
//   f_rdata=mem_rdata. Back-to-back fetch grants give back-to-back rvalids.
//  Read after write same address: write at N, read grant at N+1 returns new data at N+2.
//  imem zeroes its output on write cycles; f_rvalid never asserted in cycle after a
//   loader grant unless a fetch was granted in the preceding cycle (cannot, 1 grant/cycle).
//  Reset mid-operation: pending f_rvalid dropped (0), burst_cnt cleared, back to BOOT.
//  Requesters must hold req/addr/data stable until granted; arbiter is stateless w.r.t.
//   request content.
// STRUCTURE
//  Package imem_pkg: state enum {ST_BOOT, ST_RUN}; MEM_READ=1'b1, MEM_WRITE=1'b0;
//   default IMEM_DEPTH=64 shared with imem.
//  Single module; no sub-module (burst counter inline).
// TESTING
//  1 Reset, BOOT: f_req=1 addr 1 for 5 cycles -> f_gnt=0, booting=1, mem_rw=1 throughout.
//  2 BOOT load addr 1..5 = 00108093..ffdff1ef, load_done; fetch 1..5 back-to-back ->
//    f_rvalid cycles 2..6 after first grant, data matches in order.
//  3 RUN, l_req and f_req held 10 cycles, MAX_BURST=4 -> grant pattern L,L,L,L,F repeat.
//  4 l_addr=64 (DEPTH=64) -> l_err pulse, mem_rw stays 1, mem[0..63] unchanged.
//  5 Write addr 3 = 0xDEADBEEF at N, fetch addr 3 at N+1 -> f_rdata=0xDEADBEEF at N+2.
//  6 Assert reset while f_rvalid due -> f_rvalid=0, booting=1, burst_cnt=0 next edge.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and the imem it fronts.
package imem_pkg;

  // Arbiter top-level state: BOOT holds fetch off until the loader finishes.
  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Encoding of the imem rw pin.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  // Number of valid word entries in imem; addresses at or above this are dropped.
  localparam int IMEM_DEPTH = 64;

endpackage : imem_pkg

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-port instruction memory between the fetch port and
// the program loader. Boot phase lets only the loader in; afterwards the loader
// has priority but may hold the slot for at most MAX_BURST cycles while fetch waits.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int DEPTH     = IMEM_DEPTH,
  parameter int MAX_BURST = 4,
  parameter int BOOT_HOLD = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_err,
  input  logic          load_done,
  output logic          booting,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rw,
  input  logic [DW-1:0] mem_rdata
);

  // Counter just wide enough to hold MAX_BURST.
  localparam int              CW          = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   BURST_CAP   = CW'(MAX_BURST);
  localparam logic [CW-1:0]   CNT_ZERO    = CW'(0);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);
  localparam logic [AW-1:0]   DEPTH_LIM   = AW'(DEPTH);
  localparam state_t          RESET_STATE = (BOOT_HOLD != 0) ? ST_BOOT : ST_RUN;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] burst_cnt;
  logic          l_in_range;
  logic          l_slot;

  assign l_in_range = (l_addr < DEPTH_LIM);
  // A dropped out-of-range request still consumes the slot like a real grant.
  assign l_slot     = l_gnt | l_err;
  assign f_rdata    = mem_rdata;
  assign booting    = (state == ST_BOOT);

  // State register: BOOT/RUN, returns to the reset state asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: BOOT leaves on load_done; RUN is only left through reset.
  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT: begin
        if (load_done) begin
          next_state = ST_RUN;
        end else begin
          next_state = ST_BOOT;
        end
      end
      ST_RUN: begin
        next_state = ST_RUN;
      end
      default: begin
        next_state = RESET_STATE;
      end
    endcase
  end

  // Output logic: pick the slot owner and drive grants and the imem port.
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    l_err     = 1'b0;
    mem_rw    = MEM_READ;
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    if (reset) begin
      // Hold the imem port idle (read of word 0) while reset is asserted.
      f_gnt = 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          // Fetch is locked out; the loader is served every cycle it asks.
          if (l_req) begin
            if (l_in_range) begin
              l_gnt     = 1'b1;
              mem_rw    = MEM_WRITE;
              mem_addr  = l_addr;
              mem_wdata = l_wdata;
            end else begin
              l_err = 1'b1;
            end
          end else begin
            l_gnt = 1'b0;
          end
        end
        ST_RUN: begin
          // Loader wins unless it has already used up its burst while fetch waited.
          if (l_req && !(f_req && (burst_cnt == BURST_CAP))) begin
            if (l_in_range) begin
              l_gnt     = 1'b1;
              mem_rw    = MEM_WRITE;
              mem_addr  = l_addr;
              mem_wdata = l_wdata;
            end else begin
              l_err = 1'b1;
            end
          end else if (f_req) begin
            f_gnt    = 1'b1;
            mem_addr = f_addr;
          end else begin
            f_gnt = 1'b0;
          end
        end
        default: begin
          f_gnt = 1'b0;
        end
      endcase
    end
  end

  // Burst counter: counts loader slots taken while fetch is waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      burst_cnt <= CNT_ZERO;
    end else if (state != ST_RUN) begin
      burst_cnt <= CNT_ZERO;
    end else if (f_gnt || !f_req) begin
      burst_cnt <= CNT_ZERO;
    end else if (l_slot && (burst_cnt != BURST_CAP)) begin
      burst_cnt <= burst_cnt + CNT_ONE;
    end else begin
      burst_cnt <= burst_cnt;
    end
  end

  // Read-data valid: imem output belongs to the fetch granted one cycle earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_rvalid <= 1'b0;
    end else begin
      f_rvalid <= f_gnt;
    end
  end

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural imem and a fetch-data scoreboard.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_err;
  logic        load_done;
  logic        booting;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  imem_arbiter #(
    .AW(32), .DW(32), .DEPTH(64), .MAX_BURST(4), .BOOT_HOLD(1)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt), .l_err(l_err),
    .load_done(load_done), .booting(booting),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural imem: registered read, output zeroed on write cycles.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_rw == 1'b0) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata          <= 32'h0;
    end else begin
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  logic [31:0] exp_mem [0:63];
  logic [31:0] prog    [1:5];
  logic [31:0] sb_q [$];
  int          n_cmp;
  int          n_err;
  logic        prev_fgnt;
  logic        s_fgnt, s_lgnt, s_lerr, s_rw, s_rvalid, s_booting;
  logic [31:0] s_addr, s_wdata, s_rdata;
  int          diffs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at the falling edge, run the scoreboard, return just after the rising edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    s_fgnt    = f_gnt;
    s_lgnt    = l_gnt;
    s_lerr    = l_err;
    s_rw      = mem_rw;
    s_addr    = mem_addr;
    s_wdata   = mem_wdata;
    s_rvalid  = f_rvalid;
    s_rdata   = f_rdata;
    s_booting = booting;
    check("rvalid_after_gnt", 32'(f_rvalid), 32'(prev_fgnt));
    if (f_rvalid) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rdata", f_rdata, e);
      end else begin
        check("rvalid_without_fetch", 32'(f_rvalid), 32'd0);
      end
    end
    if (f_gnt) begin
      sb_q.push_back(exp_mem[f_addr[5:0]]);
    end
    prev_fgnt = f_gnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    prev_fgnt = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     <= 32'h0;
      exp_mem[i]  = 32'h0;
    end
    prog[1] = 32'h00108093;
    prog[2] = 32'h00208113;
    prog[3] = 32'h00310193;
    prog[4] = 32'h00418213;
    prog[5] = 32'hffdff1ef;
    reset = 1'b1; f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0;
    l_addr = 32'h0; l_wdata = 32'h0; load_done = 1'b0;

    // Reset state.
    tick();
    check("rst_f_gnt",   32'(s_fgnt),    32'd0);
    check("rst_l_gnt",   32'(s_lgnt),    32'd0);
    check("rst_l_err",   32'(s_lerr),    32'd0);
    check("rst_rvalid",  32'(s_rvalid),  32'd0);
    check("rst_mem_rw",  32'(s_rw),      32'd1);
    check("rst_addr",    s_addr,         32'd0);
    check("rst_wdata",   s_wdata,        32'd0);
    check("rst_booting", 32'(s_booting), 32'd1);
    reset = 1'b0;

    // BOOT: fetch is held off.
    f_req = 1'b1; f_addr = 32'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("boot_f_gnt",   32'(s_fgnt),    32'd0);
      check("boot_booting", 32'(s_booting), 32'd1);
      check("boot_mem_rw",  32'(s_rw),      32'd1);
    end
    f_req = 1'b0;

    // BOOT: load five words.
    for (int i = 1; i <= 5; i++) begin
      l_req = 1'b1; l_addr = 32'(i); l_wdata = prog[i];
      exp_mem[i] = prog[i];
      tick();
      check("load_l_gnt",  32'(s_lgnt), 32'd1);
      check("load_mem_rw", 32'(s_rw),   32'd0);
      check("load_addr",   s_addr,      32'(i));
      check("load_wdata",  s_wdata,     prog[i]);
    end
    l_req = 1'b0;
    load_done = 1'b1;
    tick();
    check("done_cycle_booting", 32'(s_booting), 32'd1);
    load_done = 1'b0;
    tick();
    check("run_booting", 32'(s_booting), 32'd0);

    // RUN: back-to-back fetches of the loaded program.
    for (int i = 1; i <= 5; i++) begin
      f_req = 1'b1; f_addr = 32'(i);
      tick();
      check("fetch_f_gnt",  32'(s_fgnt), 32'd1);
      check("fetch_addr",   s_addr,      32'(i));
      check("fetch_mem_rw", 32'(s_rw),   32'd1);
      if (i > 1) begin
        check("fetch_b2b_rvalid", 32'(s_rvalid), 32'd1);
      end
    end
    f_req = 1'b0;
    tick();
    check("fetch_last_rvalid", 32'(s_rvalid), 32'd1);
    tick();
    check("sb_drained_1", 32'(sb_q.size()), 32'd0);

    // RUN: contention, expect L,L,L,L,F repeating.
    l_req = 1'b1; l_addr = 32'd10; l_wdata = 32'hA5A50010; exp_mem[10] = 32'hA5A50010;
    f_req = 1'b1; f_addr = 32'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("burst_f_gnt", 32'(s_fgnt), ((i % 5) == 4) ? 32'd1 : 32'd0);
      check("burst_l_gnt", 32'(s_lgnt), ((i % 5) == 4) ? 32'd0 : 32'd1);
    end
    l_req = 1'b0; f_req = 1'b0;
    tick();

    // Out-of-range loader address.
    l_req = 1'b1; l_addr = 32'd64; l_wdata = 32'hBAD00040;
    tick();
    check("oor_l_err",  32'(s_lerr), 32'd1);
    check("oor_l_gnt",  32'(s_lgnt), 32'd0);
    check("oor_mem_rw", 32'(s_rw),   32'd1);
    l_addr = 32'd100; f_req = 1'b1; f_addr = 32'd2;
    tick();
    check("oor_slot_l_err", 32'(s_lerr), 32'd1);
    check("oor_slot_f_gnt", 32'(s_fgnt), 32'd0);
    check("oor_slot_rw",    32'(s_rw),   32'd1);
    l_req = 1'b0;
    tick();
    check("oor_after_f_gnt", 32'(s_fgnt), 32'd1);
    check("oor_after_l_err", 32'(s_lerr), 32'd0);
    f_req = 1'b0;
    tick();
    diffs = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] !== exp_mem[i]) diffs++;
    end
    check("mem_intact", 32'(diffs), 32'd0);

    // load_done while running is ignored.
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    tick();
    check("run_load_done_ignored", 32'(s_booting), 32'd0);

    // Read after write to the same address.
    l_req = 1'b1; l_addr = 32'd3; l_wdata = 32'hDEADBEEF; exp_mem[3] = 32'hDEADBEEF;
    tick();
    check("raw_l_gnt", 32'(s_lgnt), 32'd1);
    l_req = 1'b0; f_req = 1'b1; f_addr = 32'd3;
    tick();
    check("raw_f_gnt", 32'(s_fgnt), 32'd1);
    f_req = 1'b0;
    tick();
    check("raw_rvalid", 32'(s_rvalid), 32'd1);
    check("raw_rdata",  s_rdata,       32'hDEADBEEF);

    // Reset while a fetch response is due and the burst counter is non-zero.
    l_req = 1'b1; l_addr = 32'd20; l_wdata = 32'h00000001; exp_mem[20] = 32'h00000001;
    f_req = 1'b1; f_addr = 32'd4;
    tick();
    tick();
    check("pre_rst_burst_cnt", 32'(dut.burst_cnt), 32'd2);
    l_req = 1'b0;
    @(negedge clk);
    check("pre_rst_f_gnt", 32'(f_gnt), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid",    32'(f_rvalid),      32'd0);
    check("mid_rst_booting",   32'(booting),       32'd1);
    check("mid_rst_burst_cnt", 32'(dut.burst_cnt), 32'd0);
    check("mid_rst_f_gnt",     32'(f_gnt),         32'd0);
    @(posedge clk);
    #1;
    check("mid_rst_rvalid_edge", 32'(f_rvalid), 32'd0);
    f_req = 1'b0;
    reset = 1'b0;
    sb_q.delete();
    prev_fgnt = 1'b0;
    tick();
    check("post_rst_booting", 32'(s_booting), 32'd1);
    check("post_rst_rvalid",  32'(s_rvalid),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_imem_arbiter
